// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID register for the RV32I pipeline.
// Owns the PC and drives a one-outstanding req/rvalid instruction fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lwStall,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] dinstr;

    assign redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    assign target   = (PCSrcE == 2'b10) ? (ALUResultE & ~32'h1) : PCTargetE;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        deliver = 1'b0;
        dinstr  = buf_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            S_REQ: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (lwStall) begin
                        buf_d   = imem_rdata;
                        req_d   = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        dinstr  = imem_rdata;
                        pc_d    = pc_plus4;
                        addr_d  = pc_plus4;
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = S_DRAIN;
                end
            end
            // The stale response is thrown away; the newest target wins.
            S_DRAIN: begin
                if (redirect) pc_d = target;
                if (imem_rvalid) begin
                    addr_d  = redirect ? target : pc_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (!lwStall) begin
                    deliver = 1'b1;
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (lwStall) begin
            valid_d = valid_q;
        end else if (deliver) begin
            instr_d = dinstr;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            buf_q   <= NOP_INSTR;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd4;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;

endmodule
